// File: rtl/binary_lif_pkg.sv
// Shared constants and the candidate-potential helper for the binary LIF neuron.
package binary_lif_pkg;

    localparam int DEFAULT_THRESHOLD  = 5;
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_WEIGHT     = 1;
    localparam int DEFAULT_LEAK       = 1;
    localparam int DEFAULT_REFRACTORY = 0;

    // Widest membrane potential the helper can handle; the result is one bit wider.
    localparam int MAX_POT_W = 32;

    typedef logic [MAX_POT_W-1:0] pot_ext_t;
    typedef logic [MAX_POT_W:0]   cand_ext_t;

    // Candidate potential: integrate WEIGHT on a spike, otherwise leak with a floor at zero.
    // The extra top bit keeps P + WEIGHT from wrapping.
    function automatic cand_ext_t lif_next_potential(
        input pot_ext_t p,
        input logic     i,
        input pot_ext_t weight,
        input pot_ext_t leak
    );
        cand_ext_t cand;
        if (i) begin
            cand = {1'b0, p} + {1'b0, weight};
        end else if (p > leak) begin
            cand = {1'b0, p - leak};
        end else begin
            cand = {(MAX_POT_W + 1){1'b0}};
        end
        return cand;
    endfunction

endpackage

// File: rtl/binary_lif_param_check.sv
// Elaboration-time parameter sanity checks for the binary LIF neuron.
module binary_lif_param_check #(
    parameter int THRESHOLD = 5,
    parameter int WIDTH     = 8,
    parameter int WEIGHT    = 1
);

    if (THRESHOLD < 1) begin : g_thr_zero
        $error("binary_lif_neuron: THRESHOLD must be at least 1");
    end

    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_width_range
        $error("binary_lif_neuron: WIDTH must be between 1 and 32");
    end

    if (longint'(THRESHOLD) >= (64'sd1 <<< WIDTH)) begin : g_thr_big
        $error("binary_lif_neuron: THRESHOLD must be below 2**WIDTH");
    end

    if (WEIGHT < 1) begin : g_weight_zero
        $error("binary_lif_neuron: WEIGHT must be at least 1");
    end

    if (longint'(WEIGHT) >= (64'sd1 <<< WIDTH)) begin : g_weight_big
        $error("binary_lif_neuron: WEIGHT must be below 2**WIDTH");
    end

endmodule

// File: rtl/lif_refractory_counter.sv
// Refractory down-counter: loads on a spike, counts down to zero, active while nonzero.
module lif_refractory_counter #(
    parameter int REFRACTORY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active
);

    localparam int CNT_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    logic [CNT_W-1:0] count_r;

    // Load the refractory length on a spike, then count down to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= CNT_W'(REFRACTORY);
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign active = (count_r != {CNT_W{1'b0}});

endmodule

// File: rtl/binary_lif_neuron.sv
// Binary-input, binary-output leaky integrate-and-fire neuron with optional refractory period.
module binary_lif_neuron
    import binary_lif_pkg::*;
#(
    parameter int THRESHOLD  = DEFAULT_THRESHOLD,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int WEIGHT     = DEFAULT_WEIGHT,
    parameter int LEAK       = DEFAULT_LEAK,
    parameter int REFRACTORY = DEFAULT_REFRACTORY
) (
    input  logic clk,
    input  logic rst,
    input  logic I,
    output logic S
);

    localparam cand_ext_t THRESH_EXT = cand_ext_t'(THRESHOLD);
    localparam pot_ext_t  WEIGHT_EXT = pot_ext_t'(WEIGHT);
    localparam pot_ext_t  LEAK_EXT   = pot_ext_t'(LEAK);

    logic [WIDTH-1:0] p_r;
    cand_ext_t        cand_s;
    logic             fire_s;
    logic             refr_active_s;

    binary_lif_param_check #(
        .THRESHOLD (THRESHOLD),
        .WIDTH     (WIDTH),
        .WEIGHT    (WEIGHT)
    ) u_param_check ();

    if (REFRACTORY > 0) begin : g_refr
        lif_refractory_counter #(
            .REFRACTORY (REFRACTORY)
        ) u_refr (
            .clk    (clk),
            .rst    (rst),
            .load   (fire_s),
            .active (refr_active_s)
        );
    end else begin : g_no_refr
        assign refr_active_s = 1'b0;
    end

    // Candidate potential and threshold decision; firing is suppressed while refractory.
    always_comb begin
        cand_s = lif_next_potential(pot_ext_t'(p_r), I, WEIGHT_EXT, LEAK_EXT);
        fire_s = 1'b0;
        if (!refr_active_s && (cand_s >= THRESH_EXT)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Membrane potential and output spike registers; reset beats refractory beats firing.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r <= {WIDTH{1'b0}};
            S   <= 1'b0;
        end else if (refr_active_s) begin
            p_r <= {WIDTH{1'b0}};
            S   <= 1'b0;
        end else if (fire_s) begin
            p_r <= {WIDTH{1'b0}};
            S   <= 1'b1;
        end else begin
            p_r <= cand_s[WIDTH-1:0];
            S   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_binary_lif_neuron.sv
// Self-checking bench: a default neuron (a) and a REFRACTORY=3 neuron (b) against a behavioural model.
module tb_binary_lif_neuron;

    logic clk = 1'b0;
    logic rst_a, i_a, rst_b, i_b;
    logic s_a, s_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binary_lif_neuron dut_a (
        .clk (clk),
        .rst (rst_a),
        .I   (i_a),
        .S   (s_a)
    );

    binary_lif_neuron #(.REFRACTORY(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .I   (i_b),
        .S   (s_b)
    );

    // Behavioural model state per instance (potential, refractory cycles left, spike).
    int ma_p = 0, ma_r = 0, mb_p = 0, mb_r = 0;
    bit ma_s = 1'b0, mb_s = 1'b0, ma_v = 1'b0, mb_v = 1'b0;

    // One cycle of the neuron rules in plain integer arithmetic.
    task automatic model_step(input int p, input int r, input bit i, input int thr, input int w,
                              input int lk, input int refr, output int np, output int nr, output bit ns);
        int c;
        if (r > 0) begin
            np = 0; nr = r - 1; ns = 1'b0;
        end else begin
            c = i ? p + w : ((p > lk) ? p - lk : 0);
            if (c >= thr) begin
                np = 0; nr = refr; ns = 1'b1;
            end else begin
                np = c; nr = 0; ns = 1'b0;
            end
        end
    endtask

    // Model for the default instance.
    always @(posedge clk) begin : model_a
        int np, nr;
        bit ns;
        if (rst_a) begin
            ma_p <= 0; ma_r <= 0; ma_s <= 1'b0; ma_v <= 1'b1;
        end else begin
            model_step(ma_p, ma_r, i_a, 5, 1, 1, 0, np, nr, ns);
            ma_p <= np; ma_r <= nr; ma_s <= ns;
        end
    end

    // Model for the refractory instance.
    always @(posedge clk) begin : model_b
        int np, nr;
        bit ns;
        if (rst_b) begin
            mb_p <= 0; mb_r <= 0; mb_s <= 1'b0; mb_v <= 1'b1;
        end else begin
            model_step(mb_p, mb_r, i_b, 5, 1, 1, 3, np, nr, ns);
            mb_p <= np; mb_r <= nr; mb_s <= ns;
        end
    end

    // Every-cycle comparison of both DUTs against the model, away from the active edge.
    always @(negedge clk) begin
        if (ma_v) begin
            checks++;
            if ((s_a !== ma_s) || (int'(dut_a.p_r) != ma_p)) begin
                errors++;
                $display("FAIL model_a t=%0t S=%0b P=%0d expected S=%0b P=%0d", $time, s_a, dut_a.p_r, ma_s, ma_p);
            end
        end
        if (mb_v) begin
            checks++;
            if ((s_b !== mb_s) || (int'(dut_b.p_r) != mb_p)) begin
                errors++;
                $display("FAIL model_b t=%0t S=%0b P=%0d expected S=%0b P=%0d", $time, s_b, dut_b.p_r, mb_s, mb_p);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle just after it.
    task automatic step(input bit ra, input bit ia, input bit rb, input bit ib);
        rst_a = ra; i_a = ia; rst_b = rb; i_b = ib;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; i_a = 1'b0; rst_b = 1'b1; i_b = 1'b0;

        // Reset then idle: no underflow from leak.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("reset_s_a", int'(s_a), 0);
        chk("reset_p_a", int'(dut_a.p_r), 0);
        chk("reset_s_b", int'(s_b), 0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("idle_s", int'(s_a), 0);
            chk("idle_p", int'(dut_a.p_r), 0);
        end

        // Accumulate: spikes on cycles 5 and 10.
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("accum_s", int'(s_a), ((k == 5) || (k == 10)) ? 1 : 0);
            chk("accum_p", int'(dut_a.p_r), k % 5);
        end

        // Leak from 3 down to 0 and stay there.
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("leak_start_p", int'(dut_a.p_r), 3);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("leak_s", int'(s_a), 0);
            chk("leak_p", int'(dut_a.p_r), (k < 3) ? 3 - k : 0);
        end

        // Sub-threshold burst then completion.
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("burst_s", int'(s_a), (k == 5) ? 1 : 0);
            chk("burst_p", int'(dut_a.p_r), (k == 5) ? 0 : k);
        end

        // Refractory instance: spikes on cycles 5 and 13, held at 0 for 6..8.
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("refr_s", int'(s_b), ((k == 5) || (k == 13)) ? 1 : 0);
            chk("refr_p", int'(dut_b.p_r), (k < 5) ? k : ((k <= 8) ? 0 : ((k == 13) ? 0 : k - 8)));
        end

        // Reset with a pending spike (P=4, I=1).
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("pre_rst_p", int'(dut_a.p_r), 4);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_spike_s", int'(s_a), 0);
        chk("rst_spike_p", int'(dut_a.p_r), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_p", int'(dut_a.p_r), 1);

        // Reset during an active refractory period restarts integration at once.
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("refr_fire_s", int'(s_b), 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("refr_rst_s", int'(s_b), 0);
        chk("refr_rst_p", int'(dut_b.p_r), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("refr_restart_p", int'(dut_b.p_r), 1);
        chk("refr_restart_s", int'(s_b), 0);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
